// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   Multiplies take MULT_CYCLES busy cycles. Divides use a restoring divider,
//   one quotient bit per cycle, followed by one sign-fix cycle (WIDTH+1 busy
//   cycles in total).
//
// Parameters
//   WIDTH        operand / HI / LO width (even, 8..64)
//   MULT_CYCLES  busy cycles for mult/multu (1..16)
//
// Ports
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-low reset
//   start  in   one-cycle command strobe, qualified by op
//   op     in   0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 nop
//   a      in   multiplicand / dividend / mthi-mtlo write data
//   b      in   multiplier / divisor
//   busy   out  high while an operation is in flight
//   done   out  one-cycle pulse in the cycle after HI/LO take a result
//   hi     out  HI register
//   lo     out  LO register
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Wide enough for WIDTH-1 (<=63) and MULT_CYCLES-1 (<=15).
    localparam int CNT_W = 7;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    // opa_reg: multiplicand, or the original dividend (needed for divide by zero).
    // opb_reg: multiplier, or the divisor magnitude.
    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
    logic             mul_signed_reg;

    // Divider working state: quo_reg starts as the dividend magnitude and
    // shifts left each step while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             dz_reg;

    // ---------------- multiplier datapath ----------------
    logic [2*WIDTH-1:0] mul_a_ext;
    logic [2*WIDTH-1:0] mul_b_ext;
    logic [2*WIDTH-1:0] product;

    // Sign/zero extension to 2*WIDTH makes a single modular multiply give
    // the correct low 2*WIDTH bits for both signed and unsigned products.
    assign mul_a_ext = {{WIDTH{mul_signed_reg & opa_reg[WIDTH-1]}}, opa_reg};
    assign mul_b_ext = {{WIDTH{mul_signed_reg & opb_reg[WIDTH-1]}}, opb_reg};
    assign product   = mul_a_ext * mul_b_ext;

    // ---------------- divider setup ----------------
    logic             div_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // The most-negative value maps to itself, which read as unsigned is the
    // correct magnitude 2^(WIDTH-1); overflow then falls out naturally.
    assign div_signed = (op == OP_DIV);
    assign a_abs      = (div_signed && a[WIDTH-1]) ? -a : a;
    assign b_abs      = (div_signed && b[WIDTH-1]) ? -b : b;

    // ---------------- restoring divide step ----------------
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             step_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // rem < divisor always holds, so shifted fits in WIDTH+1 bits and the
    // top bit of diff is a clean borrow flag.
    assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
    assign diff     = shifted - {1'b0, opb_reg};
    assign step_ok  = ~diff[WIDTH];
    assign rem_next = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_reg[WIDTH-2:0], step_ok};

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            mul_signed_reg <= 1'b0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            neg_q_reg      <= 1'b0;
            neg_r_reg      <= 1'b0;
            dz_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                opa_reg        <= a;
                                opb_reg        <= b;
                                mul_signed_reg <= (op == OP_MULT);
                                cnt_reg        <= CNT_W'(MULT_CYCLES - 1);
                                busy_reg       <= 1'b1;
                                state_reg      <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                opa_reg   <= a;
                                opb_reg   <= b_abs;
                                quo_reg   <= a_abs;
                                rem_reg   <= '0;
                                neg_q_reg <= div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r_reg <= div_signed & a[WIDTH-1];
                                dz_reg    <= (b == '0);
                                cnt_reg   <= CNT_W'(WIDTH - 1);
                                busy_reg  <= 1'b1;
                                state_reg <= S_DIV;
                            end
                            OP_MTHI: hi_reg <= a;
                            OP_MTLO: lo_reg <= a;
                            default: ;  // nop and reserved
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_reg == '0) begin
                        {hi_reg, lo_reg} <= product;
                        busy_reg         <= 1'b0;
                        done_reg         <= 1'b1;
                        state_reg        <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (cnt_reg == '0) begin
                        state_reg <= S_FIX;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_FIX: begin
                    if (dz_reg) begin
                        lo_reg <= '1;
                        hi_reg <= opa_reg;
                    end else begin
                        lo_reg <= neg_q_reg ? -quo_reg : quo_reg;
                        hi_reg <= neg_r_reg ? -rem_reg : rem_reg;
                    end
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
